// File: rtl/pcs_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_rx_pkg
//  Description : Shared PCS receive definitions. These are the sync header
//                codes, the BER monitor state encoding, the window timing
//                constant and the counter width.
//  Contents    : SH_DATA/SH_CTRL   valid 66b sync header codes
//                ber_state_t       BER monitor FSM states
//                BER_TIMER_125US   clk156 cycles in a 125 us window
//                BER_CNT_W         width of the BER counters
//                sh_is_bad()       invalid-header detector
//  Revision    : 1.0  initial release
// ============================================================================
package pcs_rx_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam int BER_TIMER_125US = 19531;
    localparam int BER_CNT_W       = 6;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        COUNT  = 2'd1,
        HI_BER = 2'd2
    } ber_state_t;

    // Only 01 and 10 are legal sync headers. The header is ignored when no
    // block is being presented.
    function automatic logic sh_is_bad(input logic valid, input logic [1:0] hdr);
        return valid & ~((hdr == SH_DATA) | (hdr == SH_CTRL));
    endfunction

endpackage : pcs_rx_pkg
`default_nettype wire

// File: rtl/ber_monitor_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ber_monitor_rx_if
//  Description : Bundle between the receive lane logic and the BER monitor.
//  Signals     : blk_lock        block lock from the lock FSM
//                blk_valid       strobe marking a new block header
//                sync_hdr[1:0]   sync header of the current block
//                clear_ber_count clear-on-read strobe for ber_count
//                hi_ber          high bit-error-rate flag
//                ber_count[5:0]  saturating invalid-header count
//                win_count[5:0]  invalid headers in the current window
//  Modports    : master  lane side (drives the header stream)
//                slave   monitor side
//  Revision    : 1.0  initial release
// ============================================================================
interface ber_monitor_rx_if;
    import pcs_rx_pkg::*;

    logic                 blk_lock;
    logic                 blk_valid;
    logic [1:0]           sync_hdr;
    logic                 clear_ber_count;
    logic                 hi_ber;
    logic [BER_CNT_W-1:0] ber_count;
    logic [BER_CNT_W-1:0] win_count;

    modport master (
        output blk_lock, blk_valid, sync_hdr, clear_ber_count,
        input  hi_ber, ber_count, win_count
    );

    modport slave (
        input  blk_lock, blk_valid, sync_hdr, clear_ber_count,
        output hi_ber, ber_count, win_count
    );

endinterface : ber_monitor_rx_if
`default_nettype wire

// File: rtl/ber_window_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ber_window_timer
//  Description : Free-running window timer. It counts 0..TIMER_CYCLES-1
//                while run_i is high and pulses done_o on the last count,
//                when it also wraps to 0. The count is held at 0 while it is
//                not running or while restart_i is high.
//  Ports       : clk156     core clock
//                rstb156    asynchronous active-low reset
//                run_i      advance the timer
//                restart_i  force the timer back to 0 (wins over run_i)
//                done_o     one-cycle end-of-window pulse
//  Revision    : 1.0  initial release
// ============================================================================
module ber_window_timer
    import pcs_rx_pkg::*;
#(
    parameter int TIMER_CYCLES = BER_TIMER_125US,
    parameter int TIMER_W      = 15
) (
    input  logic clk156,
    input  logic rstb156,
    input  logic run_i,
    input  logic restart_i,
    output logic done_o
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMER_CYCLES - 1);

    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    logic               done_w;

    always_comb begin
        done_w  = run_i & ~restart_i & (timer_q == LAST);
        timer_d = timer_q;
        if (restart_i || !run_i) begin
            timer_d = '0;
        end else if (done_w) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk156 or negedge rstb156) begin
        if (!rstb156) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign done_o = done_w;

endmodule : ber_window_timer
`default_nettype wire

// File: rtl/ber_monitor_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ber_monitor_rx
//  Description : BER monitor for one PCS receive lane. It counts invalid sync
//                headers inside a fixed time window and raises hi_ber when
//                HI_BER_THRESH of them land in one window. The monitor only
//                runs while block lock is held.
//  Ports       : clk156   core clock, 156.25 MHz
//                rstb156  asynchronous active-low reset
//                mon      ber_monitor_rx_if.slave. Header stream in;
//                         hi_ber, ber_count and win_count out (all
//                         registered).
//  Revision    : 1.0  initial release
// ============================================================================
module ber_monitor_rx
    import pcs_rx_pkg::*;
#(
    parameter int TIMER_CYCLES  = BER_TIMER_125US,
    parameter int HI_BER_THRESH = 16,
    parameter int TIMER_W       = 15
) (
    input  logic             clk156,
    input  logic             rstb156,
    ber_monitor_rx_if.slave  mon
);

    localparam logic [BER_CNT_W-1:0] THRESH    = BER_CNT_W'(HI_BER_THRESH);
    localparam logic [BER_CNT_W-1:0] THRESH_M1 = BER_CNT_W'(HI_BER_THRESH - 1);
    localparam logic [BER_CNT_W-1:0] CNT_MAX   = {BER_CNT_W{1'b1}};
    localparam logic [BER_CNT_W-1:0] CNT_ONE   = BER_CNT_W'(1);

    ber_state_t           state_q, state_d;
    logic                 hi_ber_q, hi_ber_d;
    logic [BER_CNT_W-1:0] win_q, win_d;
    logic [BER_CNT_W-1:0] ber_q, ber_d;

    logic                 sh_bad;
    logic                 sh_counted;
    logic                 timer_done;
    logic [BER_CNT_W-1:0] win_seed;

    assign sh_bad     = sh_is_bad(mon.blk_valid, mon.sync_hdr);
    assign sh_counted = sh_bad & (state_q != INIT);
    // A bad header that arrives on the window boundary belongs to the next
    // window.
    assign win_seed   = sh_bad ? CNT_ONE : '0;

    // Losing lock restarts the window, so the timer goes back to 0 in the
    // same cycle that the FSM falls back to INIT.
    ber_window_timer #(
        .TIMER_CYCLES (TIMER_CYCLES),
        .TIMER_W      (TIMER_W)
    ) u_timer (
        .clk156    (clk156),
        .rstb156   (rstb156),
        .run_i     (state_q != INIT),
        .restart_i (~mon.blk_lock),
        .done_o    (timer_done)
    );

    // Next-state logic and window count.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        if (!mon.blk_lock) begin
            state_d = INIT;
            win_d   = '0;
        end else begin
            case (state_q)
                INIT: begin
                    state_d = COUNT;
                    win_d   = '0;
                end
                COUNT: begin
                    if (timer_done) begin
                        // The expiring window ended below threshold. The
                        // current header opens the new window.
                        win_d = win_seed;
                        if (sh_bad && (THRESH == CNT_ONE)) begin
                            state_d = HI_BER;
                        end
                    end else if (sh_bad) begin
                        if (win_q >= THRESH_M1) begin
                            state_d = HI_BER;
                            win_d   = THRESH;
                        end else begin
                            win_d = win_q + 1'b1;
                        end
                    end
                end
                HI_BER: begin
                    if (timer_done) begin
                        state_d = COUNT;
                        win_d   = win_seed;
                    end else if (sh_bad && (win_q < THRESH)) begin
                        win_d = win_q + 1'b1;
                    end
                end
                default: begin
                    state_d = INIT;
                    win_d   = '0;
                end
            endcase
        end
        hi_ber_d = (state_d == HI_BER);
    end

    // Saturating lifetime counter. A clear that lands on a bad header keeps
    // that header.
    always_comb begin
        ber_d = ber_q;
        if (mon.clear_ber_count) begin
            ber_d = sh_counted ? CNT_ONE : '0;
        end else if (sh_counted && (ber_q != CNT_MAX)) begin
            ber_d = ber_q + 1'b1;
        end
    end

    always_ff @(posedge clk156 or negedge rstb156) begin
        if (!rstb156) begin
            state_q  <= INIT;
            hi_ber_q <= 1'b0;
            win_q    <= '0;
            ber_q    <= '0;
        end else begin
            state_q  <= state_d;
            hi_ber_q <= hi_ber_d;
            win_q    <= win_d;
            ber_q    <= ber_d;
        end
    end

    assign mon.hi_ber    = hi_ber_q;
    assign mon.ber_count = ber_q;
    assign mon.win_count = win_q;

endmodule : ber_monitor_rx
`default_nettype wire

// File: tb/tb_ber_monitor_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ber_monitor_rx
//  Description : Self-checking bench for ber_monitor_rx. It uses a 100-cycle
//                window and a threshold of 16. Each step drives one cycle of
//                input, waits for the clock edge and then compares the
//                registered outputs 1 ns later.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ber_monitor_rx;
    import pcs_rx_pkg::*;

    localparam int TC = 100;
    localparam int TH = 16;
    localparam int TW = 15;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    ber_monitor_rx_if bus ();

    ber_monitor_rx #(
        .TIMER_CYCLES  (TC),
        .HI_BER_THRESH (TH),
        .TIMER_W       (TW)
    ) dut (
        .clk156  (clk),
        .rstb156 (rstb),
        .mon     (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       lock;
        logic       valid;
        logic [1:0] hdr;
        logic       clr;
        logic       exp_hi;
        logic [5:0] exp_ber;
        logic [5:0] exp_win;
    } vec_t;

    vec_t vtab[15];

    task automatic chk(input string name, input logic ehi,
                       input logic [5:0] eber, input logic [5:0] ewin);
        checks++;
        if (bus.hi_ber !== ehi || bus.ber_count !== eber || bus.win_count !== ewin) begin
            errors++;
            $display("FAIL %s: got hi_ber=%0d ber_count=%0d win_count=%0d, expected hi_ber=%0d ber_count=%0d win_count=%0d",
                     name, bus.hi_ber, bus.ber_count, bus.win_count, ehi, eber, ewin);
        end
    endtask

    task automatic step(input logic lk, input logic v, input logic [1:0] h, input logic c);
        bus.blk_lock        = lk;
        bus.blk_valid       = v;
        bus.sync_hdr        = h;
        bus.clear_ber_count = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int nb;
        int tot;
        logic bad;

        // Stimulus table. Rows 1 and 14 take INIT to COUNT. Rows 12 and 13
        // drop the lock.
        vtab[0]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 6'd0, 6'd0};
        vtab[1]  = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 6'd0, 6'd0};
        vtab[2]  = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 6'd0, 6'd0};
        vtab[3]  = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 6'd0, 6'd0};
        vtab[4]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 6'd1, 6'd1};
        vtab[5]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 6'd1, 6'd1};
        vtab[6]  = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 6'd2, 6'd2};
        vtab[7]  = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 6'd2, 6'd2};
        vtab[8]  = '{1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 6'd0, 6'd2};
        vtab[9]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 6'd1, 6'd3};
        vtab[10] = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 6'd1, 6'd4};
        vtab[11] = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 6'd1, 6'd4};
        vtab[12] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 6'd1, 6'd0};
        vtab[13] = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 6'd1, 6'd0};
        vtab[14] = '{1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 6'd0, 6'd0};

        // Reset: hold busy inputs and confirm that the outputs stay 0.
        bus.blk_lock = 1'b1; bus.blk_valid = 1'b1; bus.sync_hdr = 2'b11; bus.clear_ber_count = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 1'b0, 6'd0, 6'd0);
        bus.blk_lock = 1'b0; bus.blk_valid = 1'b0; bus.sync_hdr = 2'b01;
        rstb = 1'b1;

        for (int i = 0; i < 15; i++) begin
            step(vtab[i].lock, vtab[i].valid, vtab[i].hdr, vtab[i].clr);
            chk($sformatf("vec%0d", i), vtab[i].exp_hi, vtab[i].exp_ber, vtab[i].exp_win);
        end

        // Three windows of legal headers.
        for (int k = 0; k < 3 * TC; k++) begin
            step(1'b1, 1'b1, (k % 2 == 1) ? 2'b10 : 2'b01, 1'b0);
            chk($sformatf("clean_k%0d", k), 1'b0, 6'd0, 6'd0);
        end

        // 16 bad headers in one window, at k=0,5,...,75. The flag is high
        // from k=75 up to the end of the window. ber_count is cleared on
        // the last cycle of the window.
        for (int k = 0; k < TC; k++) begin
            bad = (k % 5 == 0) && (k < 80);
            nb  = (k < 80) ? (k / 5 + 1) : 16;
            step(1'b1, 1'b1, bad ? 2'b11 : 2'b01, k == TC - 1);
            chk($sformatf("thresh_k%0d", k), (k >= 75) && (k < TC - 1),
                (k == TC - 1) ? 6'd0 : 6'(nb), (k == TC - 1) ? 6'd0 : 6'(nb));
        end

        // 15 bad headers per window for 4 windows: one short of threshold.
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < TC; k++) begin
                bad = (k % 6 == 0) && (k <= 84);
                nb  = (k <= 84) ? (k / 6 + 1) : 15;
                step(1'b1, 1'b1, bad ? 2'b00 : 2'b10, 1'b0);
                chk($sformatf("below_w%0d_k%0d", w, k), 1'b0, 6'(15 * w + nb),
                    (k == TC - 1) ? 6'd0 : 6'(nb));
            end
        end

        // The first four bad headers saturate ber_count. The window then
        // reaches 15, and a bad header on the boundary cycle seeds the next
        // window.
        tot = 0;
        for (int k = 0; k < TC; k++) begin
            bad = (k < 4) || (k >= 10 && k < 21) || (k == TC - 1);
            if (bad) tot++;
            nb = (k == TC - 1) ? 1 : ((tot > 15) ? 15 : tot);
            step(1'b1, 1'b1, bad ? 2'b11 : 2'b01, 1'b0);
            chk($sformatf("sat_k%0d", k), 1'b0, (60 + tot > 63) ? 6'd63 : 6'(60 + tot), 6'(nb));
        end

        // The seed counts toward the threshold: 15 more bad headers assert
        // hi_ber. Then the lock is dropped while hi_ber is high.
        step(1'b1, 1'b1, 2'b01, 1'b1);
        chk("seed_kept", 1'b0, 6'd0, 6'd1);
        for (int k = 1; k <= 15; k++) begin
            step(1'b1, 1'b1, 2'b11, 1'b0);
            chk($sformatf("seeded_k%0d", k), k == 15, 6'(k), 6'(k + 1));
        end
        step(1'b1, 1'b1, 2'b11, 1'b0);
        chk("hiber_win_sat", 1'b1, 6'd16, 6'd16);
        step(1'b0, 1'b0, 2'b01, 1'b0);
        chk("lock_drop", 1'b0, 6'd16, 6'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 2'b00, 1'b0);
            chk($sformatf("unlocked_%0d", k), 1'b0, 6'd16, 6'd0);
        end
        step(1'b1, 1'b0, 2'b01, 1'b0);
        chk("relock", 1'b0, 6'd16, 6'd0);

        // Clear together with a bad header. Count up to 9, then clear with a
        // bad header again.
        step(1'b1, 1'b1, 2'b11, 1'b1);
        chk("clear_bad_a", 1'b0, 6'd1, 6'd1);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b1, 2'b11, 1'b0);
        end
        chk("count_to_9", 1'b0, 6'd9, 6'd9);
        step(1'b1, 1'b1, 2'b00, 1'b1);
        chk("clear_bad_at_9", 1'b0, 6'd1, 6'd10);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1, 2'b11, 1'b0);
        end
        chk("hiber_before_reset", 1'b1, 6'd7, 6'd16);

        // Asynchronous reset mid-window, between clock edges.
        #3;
        rstb = 1'b0;
        #1;
        chk("async_reset_now", 1'b0, 6'd0, 6'd0);
        @(posedge clk);
        #1;
        chk("async_reset_held", 1'b0, 6'd0, 6'd0);
        rstb = 1'b1;
        step(1'b0, 1'b1, 2'b11, 1'b0);
        chk("after_reset", 1'b0, 6'd0, 6'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ber_monitor_rx
`default_nettype wire
